// File: rtl/mole_round_controller.sv
// mole_round_controller
// Round sequencer for the whack-a-box game: picks a target box from the
// mapped LFSR value, lights it for a bounded show window, judges the
// player's strike and keeps score, misses and round count until the game
// ends, either by exhausting the rounds or by reaching the miss limit.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for start
// GAP    | blank interval between rounds, no box lit
// PICK   | sample box_rand, reject repeats of the previous target (max 3x)
// SHOW   | target lit, waiting for a strike or the show timeout
// JUDGE  | one-cycle round_done, count the round, decide GAP or OVER
// OVER   | game finished, results held, waiting for start

module mole_round_controller #(
    parameter logic [31:0] SHOW_CYCLES = 32'd50_000_000,
    parameter logic [31:0] GAP_CYCLES  = 32'd12_500_000,
    parameter logic [7:0]  MAX_ROUNDS  = 8'd20,
    parameter logic [3:0]  MAX_MISSES  = 4'd5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] box_rand,
    input  logic       hit_valid,
    input  logic [2:0] hit_box,
    output logic [2:0] target_box,
    output logic       target_valid,
    output logic       round_done,
    output logic       hit_flag,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic [7:0] rounds,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_PICK,
        S_SHOW,
        S_JUDGE,
        S_OVER
    } state_t;

    state_t      state;
    logic [31:0] timer;
    logic [1:0]  retry;
    logic [2:0]  last_box;

    logic [2:0]  pick_box;
    logic [7:0]  score_inc;
    logic [3:0]  misses_inc;
    logic [7:0]  rounds_next;

    // Map illegal LFSR values onto box 1 and precompute saturating increments
    always_comb begin
        pick_box    = ((box_rand >= 3'd1) && (box_rand <= 3'd4)) ? box_rand : 3'd1;
        score_inc   = (score == 8'hFF) ? score : score + 8'd1;
        misses_inc  = (misses == 4'hF) ? misses : misses + 4'd1;
        rounds_next = rounds + 8'd1;
    end

    // Round sequencing FSM with registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            timer        <= '0;
            retry        <= '0;
            last_box     <= '0;
            target_box   <= '0;
            target_valid <= 1'b0;
            round_done   <= 1'b0;
            hit_flag     <= 1'b0;
            score        <= '0;
            misses       <= '0;
            rounds       <= '0;
            game_over    <= 1'b0;
        end else begin
            round_done <= 1'b0;
            case (state)
                S_IDLE, S_OVER: begin
                    // last_box deliberately survives a restart so the first
                    // target of a new game still avoids the previous one
                    if (start) begin
                        state     <= S_GAP;
                        score     <= '0;
                        misses    <= '0;
                        rounds    <= '0;
                        hit_flag  <= 1'b0;
                        timer     <= '0;
                        game_over <= 1'b0;
                    end
                end
                S_GAP: begin
                    target_box <= '0;
                    if (timer == GAP_CYCLES - 32'd1) begin
                        timer <= '0;
                        state <= S_PICK;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_PICK: begin
                    if ((pick_box != last_box) || (retry == 2'd3)) begin
                        target_box   <= pick_box;
                        last_box     <= pick_box;
                        retry        <= '0;
                        target_valid <= 1'b1;
                        timer        <= '0;
                        state        <= S_SHOW;
                    end else begin
                        retry <= retry + 2'd1;
                    end
                end
                S_SHOW: begin
                    // A strike on the final show cycle wins over the timeout
                    if (hit_valid || (timer == SHOW_CYCLES - 32'd1)) begin
                        target_box   <= '0;
                        target_valid <= 1'b0;
                        timer        <= '0;
                        round_done   <= 1'b1;
                        state        <= S_JUDGE;
                        if (hit_valid && (hit_box == target_box)) begin
                            hit_flag <= 1'b1;
                            score    <= score_inc;
                        end else begin
                            hit_flag <= 1'b0;
                            misses   <= misses_inc;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                S_JUDGE: begin
                    rounds <= rounds_next;
                    if (misses == MAX_MISSES) begin
                        state     <= S_OVER;
                        game_over <= 1'b1;
                    end else if (rounds_next == MAX_ROUNDS) begin
                        state     <= S_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state <= S_GAP;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_round_controller.sv
// Testbench for mole_round_controller with a round-level reference model.
module tb_mole_round_controller;

    localparam int S  = 8;
    localparam int G  = 4;
    localparam int R  = 3;
    localparam int MM = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] box_rand = 3'd1;
    logic       hit_valid = 1'b0;
    logic [2:0] hit_box = 3'd0;
    logic [2:0] target_box;
    logic       target_valid;
    logic       round_done;
    logic       hit_flag;
    logic [7:0] score;
    logic [3:0] misses;
    logic [7:0] rounds;
    logic       game_over;

    mole_round_controller #(
        .SHOW_CYCLES(32'd8),
        .GAP_CYCLES (32'd4),
        .MAX_ROUNDS (8'd3),
        .MAX_MISSES (4'd2)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .box_rand    (box_rand),
        .hit_valid   (hit_valid),
        .hit_box     (hit_box),
        .target_box  (target_box),
        .target_valid(target_valid),
        .round_done  (round_done),
        .hit_flag    (hit_flag),
        .score       (score),
        .misses      (misses),
        .rounds      (rounds),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: game-level bookkeeping
    int exp_score;
    int exp_misses;
    int exp_rounds;
    int exp_last;
    bit exp_flag;
    bit exp_over;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_score  = 0;
        exp_misses = 0;
        exp_rounds = 0;
        exp_flag   = 1'b0;
        exp_over   = 1'b0;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        start     = 1'b0;
        hit_valid = 1'b0;
        repeat (3) step();
        checks++;
        if ({target_box, target_valid, round_done, hit_flag, score, misses, rounds, game_over} !== 27'd0)
            $display("FAIL reset_outputs: got tb=%0d tv=%0d rd=%0d sc=%0d mi=%0d ro=%0d go=%0d required all 0",
                     target_box, target_valid, round_done, score, misses, rounds, game_over);
        #1 resetn = 1'b1;
        exp_last = 0;
        model_clear();
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({target_box, target_valid, round_done, hit_flag, score, misses, rounds, game_over} !== 27'd0) begin
                failures++;
                $display("FAIL idle_outputs cycle %0d: got tb=%0d tv=%0d rd=%0d go=%0d required all 0",
                         i, target_box, target_valid, round_done, game_over);
            end
        end
    endtask

    task automatic start_game();
        start = 1'b1;
        step();
        start = 1'b0;
        model_clear();
        checks++;
        if ({game_over, score, misses, rounds, hit_flag, target_valid} !== 23'd0) begin
            failures++;
            $display("FAIL start_clear: got go=%0d sc=%0d mi=%0d ro=%0d hf=%0d tv=%0d required all 0",
                     game_over, score, misses, rounds, hit_flag, target_valid);
        end
    endtask

    // One full round from the first GAP cycle to the cycle after JUDGE.
    // mode: 0 = no strike (timeout), 1 = correct box, 2 = wrong box
    task automatic play_round(input logic [2:0] br, input int mode, input int d, input bit rnd);
        int v;
        int pick_len;
        int k;
        int lit;
        int want_lit;
        logic [2:0] hb;
        box_rand = br;
        v = (br >= 3'd1 && br <= 3'd4) ? int'(br) : 1;
        pick_len = (v != exp_last) ? 1 : 4;
        exp_last = v;
        k = 0;
        while (target_valid !== 1'b1 && k < 50) begin
            checks++;
            if (target_box !== 3'd0) begin
                failures++;
                $display("FAIL gap_target_box: got %0d required 0", target_box);
            end
            if (rnd) begin
                hit_valid = ($urandom % 3) == 0;
                hit_box   = 3'($urandom % 8);
                start     = 1'($urandom % 2);
            end
            step();
            k++;
        end
        hit_valid = 1'b0;
        checks++;
        if (k != G + pick_len) begin
            failures++;
            $display("FAIL show_latency: got %0d cycles required %0d", k, G + pick_len);
        end
        if (target_valid !== 1'b1) begin
            start = 1'b0;
            return;
        end
        hb = 3'd0;
        if (mode == 2) begin
            hb = 3'($urandom % 8);
            while (int'(hb) == v) hb = 3'($urandom % 8);
        end
        lit = 0;
        while (target_valid === 1'b1 && lit < S + 4) begin
            checks++;
            if (int'(target_box) != v) begin
                failures++;
                $display("FAIL show_target_box: got %0d required %0d", target_box, v);
            end
            if (mode != 0 && lit == d) begin
                hit_valid = 1'b1;
                hit_box   = (mode == 1) ? 3'(v) : hb;
            end
            if (rnd) start = 1'($urandom % 2);
            step();
            hit_valid = 1'b0;
            if (rnd) hit_box = 3'($urandom % 8);
            lit++;
        end
        start = 1'b0;
        want_lit = (mode == 0) ? S : d + 1;
        if (mode == 1) begin
            exp_flag  = 1'b1;
            exp_score = (exp_score < 255) ? exp_score + 1 : 255;
        end else begin
            exp_flag   = 1'b0;
            exp_misses = (exp_misses < 15) ? exp_misses + 1 : 15;
        end
        checks++;
        if (lit != want_lit) begin
            failures++;
            $display("FAIL lit_cycles: got %0d required %0d", lit, want_lit);
        end
        checks++;
        if (round_done !== 1'b1 || target_box !== 3'd0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL judge_pulse: got rd=%0d tb=%0d go=%0d required rd=1 tb=0 go=0",
                     round_done, target_box, game_over);
        end
        checks++;
        if (hit_flag !== exp_flag || int'(score) != exp_score || int'(misses) != exp_misses
            || int'(rounds) != exp_rounds) begin
            failures++;
            $display("FAIL judge_counts: got hf=%0d sc=%0d mi=%0d ro=%0d required hf=%0d sc=%0d mi=%0d ro=%0d",
                     hit_flag, score, misses, rounds, exp_flag, exp_score, exp_misses, exp_rounds);
        end
        exp_rounds++;
        exp_over = (exp_misses == MM) || (exp_rounds == R);
        step();
        checks++;
        if (round_done !== 1'b0 || int'(rounds) != exp_rounds || game_over !== exp_over
            || target_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_judge: got rd=%0d ro=%0d go=%0d tv=%0d required rd=0 ro=%0d go=%0d tv=0",
                     round_done, rounds, game_over, target_valid, exp_rounds, exp_over);
        end
    endtask

    task automatic finish_game();
        int guard;
        guard = 0;
        while (!exp_over && guard < 10) begin
            play_round(3'(1 + $urandom % 4), 0, 0, 1'b0);
            guard++;
        end
    endtask

    task automatic test_clean_hits();
        start_game();
        play_round(3'd2, 1, 3, 1'b0);
        play_round(3'd3, 1, 3, 1'b0);
        play_round(3'd2, 1, 3, 1'b0);
        repeat (3) step();
        checks++;
        if (score !== 8'd3 || rounds !== 8'd3 || misses !== 4'd0 || game_over !== 1'b1) begin
            failures++;
            $display("FAIL clean_hits_final: got sc=%0d ro=%0d mi=%0d go=%0d required 3 3 0 1",
                     score, rounds, misses, game_over);
        end
    endtask

    task automatic test_timeout_early_end();
        start_game();
        play_round(3'd3, 0, 0, 1'b0);
        play_round(3'd1, 0, 0, 1'b0);
        checks++;
        if (game_over !== 1'b1 || rounds !== 8'd2 || misses !== 4'd2 || score !== 8'd0) begin
            failures++;
            $display("FAIL early_end: got go=%0d ro=%0d mi=%0d sc=%0d required 1 2 2 0",
                     game_over, rounds, misses, score);
        end
    endtask

    task automatic test_wrong_and_edge();
        start_game();
        play_round(3'd1, 2, 2, 1'b0);
        play_round(3'd2, 1, 7, 1'b0);
        checks++;
        if (hit_flag !== 1'b1 || score !== 8'd1 || misses !== 4'd1) begin
            failures++;
            $display("FAIL edge_hit: got hf=%0d sc=%0d mi=%0d required 1 1 1",
                     hit_flag, score, misses);
        end
        play_round(3'd4, 0, 0, 1'b0);
    endtask

    task automatic test_repeat_rejection();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        exp_last = 0;
        step();
        start_game();
        play_round(3'd3, 1, 2, 1'b0);
        play_round(3'd3, 1, 2, 1'b0);
        play_round(3'd6, 1, 2, 1'b0);
    endtask

    task automatic test_mid_reset();
        int k;
        start_game();
        play_round(3'd2, 1, 1, 1'b0);
        box_rand = 3'd4;
        k = 0;
        while (target_valid !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        step();
        step();
        resetn = 1'b0;
        #1;
        checks++;
        if (target_box !== 3'd0 || score !== 8'd0 || target_valid !== 1'b0 || round_done !== 1'b0
            || rounds !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset: got tb=%0d sc=%0d tv=%0d rd=%0d ro=%0d required all 0",
                     target_box, score, target_valid, round_done, rounds);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (round_done !== 1'b0 || target_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: got rd=%0d tv=%0d required 0 0", round_done, target_valid);
            end
        end
        resetn = 1'b1;
        exp_last = 0;
        model_clear();
        step();
        start_game();
        play_round(3'd4, 1, 0, 1'b0);
        checks++;
        if (score !== 8'd1) begin
            failures++;
            $display("FAIL restart_after_reset: got sc=%0d required 1", score);
        end
        finish_game();
    endtask

    task automatic test_random_games();
        int guard;
        for (int g = 0; g < 8; g++) begin
            start_game();
            guard = 0;
            while (!exp_over && guard < 10) begin
                play_round(3'($urandom % 8), int'($urandom % 3), int'($urandom % S), 1'b1);
                guard++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_hits();
        test_timeout_early_end();
        test_wrong_and_edge();
        test_repeat_rejection();
        test_mid_reset();
        test_random_games();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mole_round_controller.md
# mole_round_controller

Game-round sequencer for the whack-a-box datapath. It draws a target box from the free-running LFSR box mapper and presents it for a bounded show window. It judges the player's hit against that target and accumulates score, misses and round count until the game ends. It sits between the LFSR/box-mapping logic and the board-level display and score logic.

## Interface
- SHOW_CYCLES, 50_000_000: clock cycles a target stays lit (1..2^32-1).
- GAP_CYCLES, 12_500_000: blank cycles between rounds (1..2^32-1).
- MAX_ROUNDS, 20: rounds per game (1..255).
- MAX_MISSES, 5: misses that end the game early (1..15).
- clk  in  1  system clock (CLOCK_50 at top level).
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  level; begins or restarts a game when sampled high in IDLE or OVER.
- box_rand  in  3  mapped LFSR box, valid values 1..4.
- hit_valid  in  1  single-cycle pulse; player struck a box.
- hit_box  in  3  box struck (1..4), qualified by hit_valid.
- target_box  out  3  lit box; 0 when none lit.
- target_valid  out  1  high only in SHOW.
- round_done  out  1  one-cycle pulse at end of each round.
- hit_flag  out  1  result of last round (1 = hit); held until next round_done.
- score  out  8  hits this game, saturates at 255.
- misses  out  4  misses this game.
- rounds  out  8  completed rounds this game.
- game_over  out  1  high in OVER.

## Operation
- States: IDLE, GAP, PICK, SHOW, JUDGE, OVER. Reset: IDLE; all outputs 0; timer, retry count and last_box 0.
- IDLE: start=1 -> GAP; clear score, misses, rounds, hit_flag and timer.
- GAP: target_box=0; timer counts 0..GAP_CYCLES-1; at GAP_CYCLES-1 -> PICK, timer cleared.
- PICK: sample box_rand; values 0 or 5..7 are treated as 1.
  - Accept if the value differs from last_box or retry count = 3.
  - Accept: target_box<=value, last_box<=value, retry<=0 -> SHOW.
  - Otherwise retry+1 and stay in PICK. PICK lasts 1..4 cycles.
- SHOW: target_valid=1; timer counts each cycle.
  - hit_valid with hit_box==target_box: hit; score+1, saturating.
  - hit_valid with any other hit_box: miss (wrong box); misses+1, saturating at 15.
  - Timer reaches SHOW_CYCLES-1 with no hit_valid: miss (timeout).
  - Any of the above -> JUDGE; target_box<=0; hit_flag set accordingly.
  - hit_valid on the timeout cycle: the hit is judged and the timeout ignored.
  - hit_valid outside SHOW is ignored entirely.
- JUDGE: round_done=1 for one cycle; rounds+1.
  - misses==MAX_MISSES -> OVER; else rounds(new)==MAX_ROUNDS -> OVER; else GAP.
  - Early-miss exit takes priority.
- OVER: game_over=1; score, misses and rounds held. start=1 -> same clear as IDLE -> GAP; last_box is kept.
- start is ignored in GAP, PICK, SHOW and JUDGE.
- resetn low at any time: immediate return to reset values, including mid-SHOW; no round_done.

## Timing
- start sampled at edge N: state GAP at N+1; first PICK at N+1+GAP_CYCLES.
- target_box/target_valid registered: valid the edge after PICK accepts.
- A target with no hit is lit exactly SHOW_CYCLES cycles.
- hit_valid sampled at edge M in SHOW: target_box=0, score/misses/hit_flag updated at M+1 (state JUDGE); round_done high for cycle M+1..M+2; rounds updated at M+2.
- game_over asserts the edge after JUDGE; round_done and game_over never overlap.
- Round period without retries: GAP_CYCLES + 1 + show time + 1.

## Test plan
Parameters for all scenarios: SHOW_CYCLES=8, GAP_CYCLES=4, MAX_ROUNDS=3, MAX_MISSES=2.
- Reset/idle: resetn low then high, start=0 for 20 cycles -> all outputs 0, target_valid never asserted.
- Clean hits: start pulse, box_rand=2, hit_box=2 three cycles into SHOW each round, box_rand alternating 2/3 -> score=3, rounds=3, misses=0, game_over the cycle after third round_done.
- Timeout and early end: no hits -> each target lit exactly 8 cycles; misses=2 after round 2; game_over with rounds=2.
- Wrong box plus simultaneous event: hit_box=4 on target 1 -> miss. Next round, correct hit on timer=7 -> hit_flag=1, score=1.
- Repeat rejection: box_rand stuck at 3 -> first round target 3. Second PICK lasts 4 cycles then accepts 3. box_rand=6 -> target 1.
- Mid-game reset: resetn low during SHOW -> target_box=0, score=0 immediately, no round_done. Restart via start works.
